// File: rtl/apu_frame_counter_ctrl.sv
// APU frame counter control: delayed $4017 mode apply, sequencer reset,
// quarter/half pulse generation and the frame IRQ flag.
module apu_frame_counter_ctrl #(
  parameter logic [4:0]  ADDR_FRAME  = 5'h17,
  parameter logic [4:0]  ADDR_STATUS = 5'h15,
  parameter int unsigned DELAY_EVEN  = 3,
  parameter int unsigned DELAY_ODD   = 4
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [4:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       seq_quarter_tog,
  input  logic       seq_half_tog,
  input  logic       seq_irq_tog,
  output logic       seq_mode,
  output logic       seq_mode_update,
  output logic       seq_reset,
  output logic       quarter_pulse,
  output logic       half_pulse,
  output logic       frame_irq_flag,
  output logic       irq_inhibit
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       pend_mode;
  logic       pend_mode_nxt;
  logic       apply_fire;
  logic       apply_strobe;
  logic       apu_phase;
  logic       q_sample;
  logic       h_sample;
  logic       i_sample;
  logic       irq_edge;
  logic       flag_nxt;
  logic       frame_wr;
  logic       status_rd;

  assign frame_wr  = reg_wr && (reg_addr == ADDR_FRAME);
  assign status_rd = reg_rd && (reg_addr == ADDR_STATUS);
  assign irq_edge  = seq_irq_tog != i_sample;
  assign seq_reset = reset | apply_strobe;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      pend_mode <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend_mode <= pend_mode_nxt;
    end
  end

  // A write on the apply edge lets the old apply finish and re-arms WAIT
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pend_mode_nxt = pend_mode;
    unique case (state)
      S_IDLE: ;
      S_WAIT: begin
        if (apply_fire) state_nxt = S_IDLE;
        else            cnt_nxt   = cnt - 3'd1;
      end
    endcase
    if (frame_wr) begin
      state_nxt     = S_WAIT;
      cnt_nxt       = apu_phase ? 3'(DELAY_ODD) : 3'(DELAY_EVEN);
      pend_mode_nxt = reg_wdata[7];
    end
  end

  always_comb begin
    apply_fire = (state == S_WAIT) && (cnt == 3'd1);
  end

  always_comb begin
    flag_nxt = frame_irq_flag;
    if (frame_wr && reg_wdata[6])
      flag_nxt = 1'b0;
    else if (irq_edge && !irq_inhibit && !seq_mode)
      flag_nxt = 1'b1;
    else if (status_rd)
      flag_nxt = 1'b0;
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      seq_mode        <= 1'b0;
      seq_mode_update <= 1'b0;
      apply_strobe    <= 1'b0;
      apu_phase       <= 1'b0;
      irq_inhibit     <= 1'b0;
      frame_irq_flag  <= 1'b0;
      quarter_pulse   <= 1'b0;
      half_pulse      <= 1'b0;
      q_sample        <= seq_quarter_tog;
      h_sample        <= seq_half_tog;
      i_sample        <= seq_irq_tog;
    end else begin
      apply_strobe   <= apply_fire;
      apu_phase      <= ~apu_phase;
      frame_irq_flag <= flag_nxt;
      quarter_pulse  <= seq_quarter_tog != q_sample;
      half_pulse     <= seq_half_tog != h_sample;
      q_sample       <= seq_quarter_tog;
      h_sample       <= seq_half_tog;
      i_sample       <= seq_irq_tog;
      if (apply_fire) begin
        seq_mode        <= pend_mode;
        seq_mode_update <= ~seq_mode_update;
      end
      if (frame_wr)
        irq_inhibit <= reg_wdata[6];
    end
  end

endmodule

// File: doc/apu_frame_counter_ctrl.md
Name: apu_frame_counter_ctrl

Overview:
Controller for the APU frame sequencer. It decodes CPU writes to $4017 and applies the mode change after the hardware write delay. It resets the sequencer and issues the mode-update toggle. It also converts the sequencer's toggle-style outputs into single-cycle quarter/half-frame pulses for the envelope, sweep and length units, and owns the frame IRQ flag, including the inhibit bit and clear-on-$4015-read.

Parameters:
ADDR_FRAME, 5'h17, register offset (from $4000) of the frame counter register
ADDR_STATUS, 5'h15, register offset of the status register
DELAY_EVEN, 3, cpu_clk cycles from write to apply when the write lands on an even APU phase
DELAY_ODD, 4, cpu_clk cycles from write to apply when the write lands on an odd APU phase

Ports:
cpu_clk  in  1  system clock, one tick per CPU cycle
reset  in  1  synchronous, active-high reset
reg_wr  in  1  CPU register write strobe, one cycle
reg_rd  in  1  CPU register read strobe, one cycle
reg_addr  in  5  register offset from $4000
reg_wdata  in  8  CPU write data
seq_quarter_tog  in  1  quarter-clock toggle from the sequencer
seq_half_tog  in  1  half-clock toggle from the sequencer
seq_irq_tog  in  1  frame-IRQ-request toggle from the sequencer
seq_mode  out  1  mode to the sequencer (0 = 4-step, 1 = 5-step)
seq_mode_update  out  1  mode-update toggle to the sequencer
seq_reset  out  1  sequencer counter reset
quarter_pulse  out  1  one-cycle quarter-frame strobe
half_pulse  out  1  one-cycle half-frame strobe
frame_irq_flag  out  1  frame interrupt flag; $4015 bit 6 and IRQ line contribution
irq_inhibit  out  1  current inhibit bit ($4017 bit 6)

Behaviour:
- Reset (reset=1 on a clock edge):
  - seq_mode=0, seq_mode_update=0, frame_irq_flag=0, irq_inhibit=0, quarter_pulse=0, half_pulse=0.
  - Pending write cleared, delay counter=0, apu_phase=0.
  - The three toggle sample registers load the current seq_*_tog values, so no pulse follows reset.
- seq_reset = reset OR apply_strobe (combinational OR of a registered strobe), so the sequencer is held in reset with this block.
- apu_phase: 1-bit flop, toggles every cpu_clk when not in reset.
- Frame register write (reg_wr && reg_addr==ADDR_FRAME):
  - irq_inhibit <= reg_wdata[6] immediately (visible next cycle).
  - If reg_wdata[6]=1, frame_irq_flag <= 0 in the same edge.
  - pending_mode <= reg_wdata[7]; pending valid <= 1.
  - Delay counter <= DELAY_EVEN if apu_phase==0, else DELAY_ODD.
- Delay state machine:
  - IDLE: no pending write.
  - WAIT: counter decrements by 1 per cycle.
  - APPLY: entered on the cycle the counter reaches 1. On that edge: seq_mode <= pending_mode, apply_strobe <= 1 for exactly one cycle, seq_mode_update <= ~seq_mode_update, pending cleared, then back to IDLE.
  - Write-to-apply latency, measured from the write edge to the edge where seq_mode changes: exactly DELAY_EVEN or DELAY_ODD cycles.
  - A new $4017 write during WAIT restarts the counter using the current apu_phase. The new data replaces the pending data (last write wins); only one apply occurs.
  - A write on the same edge as APPLY: the apply completes with the old data, and the new write starts a fresh WAIT.
- Pulse generation:
  - quarter_pulse <= (seq_quarter_tog != q_sample); q_sample <= seq_quarter_tog. One-cycle latency from the toggle change.
  - half_pulse: same scheme on seq_half_tog.
  - Simultaneous quarter and half changes give both pulses high in the same cycle.
  - A 5-step mode write causes the sequencer to toggle immediately on mode_update. The resulting pulses pass through this same path; no separate immediate-clock logic exists here.
- Frame IRQ flag:
  - A change on seq_irq_tog (edge-detected as above) sets frame_irq_flag when irq_inhibit==0 and seq_mode==0.
  - reg_rd && reg_addr==ADDR_STATUS clears the flag on the next edge.
  - Precedence, highest first: inhibit-write clear, then sequencer set, then status-read clear. A set and a read on the same edge leaves the flag at 1.
  - Reads of other addresses have no effect. Writes to other addresses are ignored entirely.
- Reset mid-WAIT discards the pending write; seq_mode returns to 0.

Test Plan:
1. Reset, then write $4017=8'h80 with apu_phase=0 → seq_mode=1 and seq_mode_update toggles exactly 3 edges after the write edge; seq_reset is high for 1 cycle on that edge.
2. Same write with apu_phase=1 → latency 4 cycles. Write 8'h00 then 8'h80 two cycles apart → a single apply with seq_mode=1, timed from the second write.
3. Toggle seq_quarter_tog, and seq_half_tog on the same cycle → quarter_pulse and half_pulse both high for exactly 1 cycle, 1 cycle later. Toggle seq_quarter_tog alone → only quarter_pulse.
4. mode 0, inhibit 0; toggle seq_irq_tog → frame_irq_flag=1. reg_rd at 5'h15 → flag 0 next cycle. Toggle seq_irq_tog on the same cycle as a status read → flag stays 1.
5. Flag=1, write $4017=8'h40 → flag 0 next cycle, irq_inhibit=1. A further seq_irq_tog change → flag remains 0.
6. Write $4017=8'h80, assert reset 2 cycles later → no apply occurs, seq_mode=0, no quarter_pulse or half_pulse after reset is released.
